// File: rtl/run_ctl.sv
// Front-panel run controller: debounces run/step/stop buttons and sequences
// single-cycle instruction-issue enables for the core in idle/run/step/halt modes.
module run_ctl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_sim,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_stop,
   input  logic [3:0]       sw_speed,
   input  logic             cpu_halted,
   output logic             cpu_en,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] step_count,
   output logic             busy
);

   localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] THR_M1 = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   // Button index 0 = run, 1 = step, 2 = stop.
   logic [2:0]    w_raw;
   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_deb;
   logic [2:0]    r_press;
   logic [DW-1:0] r_cnt [3];
   logic [DW-1:0] w_thr_m1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_div;
   logic [3:0]       w_div_nxt;
   logic             w_en_nxt;
   logic             w_busy_nxt;
   logic             r_en;
   logic             r_busy;
   logic [CNT_W-1:0] r_count;

   assign w_raw    = {btn_stop, btn_step, btn_run};
   assign w_thr_m1 = in_sim ? {DW{1'b0}} : THR_M1;

   // Synchronize and debounce each button; press pulse marks an accepted rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
         r_deb   <= 3'b000;
         r_press <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= {DW{1'b0}};
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
               if (r_cnt[i] >= w_thr_m1) begin
                  r_deb[i]   <= r_sync2[i];
                  r_cnt[i]   <= {DW{1'b0}};
                  r_press[i] <= r_sync2[i];
               end else begin
                  r_cnt[i]   <= r_cnt[i] + DW'(1);
                  r_press[i] <= 1'b0;
               end
            end else begin
               r_cnt[i]   <= {DW{1'b0}};
               r_press[i] <= 1'b0;
            end
         end
      end
   end

   // Mode next-state, issue enable and free-run divider; halt beats stop beats step beats run.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_en_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else if (r_press[2]) begin
               w_state_nxt = ST_IDLE;
            end else if (r_press[1]) begin
               w_state_nxt = ST_STEP;
               w_en_nxt    = 1'b1;
            end else if (r_press[0]) begin
               w_state_nxt = ST_RUN;
               w_div_nxt   = 4'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else if (r_press[2]) begin
               w_state_nxt = ST_IDLE;
            end else if (r_div >= sw_speed) begin
               w_en_nxt  = 1'b1;
               w_div_nxt = 4'd0;
            end else begin
               w_div_nxt = r_div + 4'd1;
            end
         end
         ST_STEP: begin
            if (cpu_halted) begin
               w_state_nxt = ST_HALT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
   end

   // Mode, enable, busy and saturating issue counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_div   <= 4'd0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_count <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_en    <= w_en_nxt;
         r_busy  <= w_busy_nxt;
         if (w_en_nxt && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_count <= r_count;
         end
      end
   end

   assign cpu_en     = r_en;
   assign mode       = r_state;
   assign step_count = r_count;
   assign busy       = r_busy;

endmodule

// File: doc/run_ctl.md
Name: run_ctl

Overview:
- Sequences instruction issue for the processor core from the front-panel buttons. It debounces the run, step and stop buttons, then runs a mode FSM (idle, free-run, single-step, halted).
- Emits a one-cycle `cpu_en` pulse per instruction the datapath may retire, and keeps an issued-instruction counter.
- Sits between the IO controller's button inputs and the CPU's clock-enable. It replaces direct button-to-core wiring.

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles needed to accept a button level change. Minimum 1.
- `CNT_W`, default 16: width of `step_count`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_sim` input 1: 1 forces the debounce threshold to 1 cycle.
- `btn_run` input 1: raw run button, active-high.
- `btn_step` input 1: raw single-step button, active-high.
- `btn_stop` input 1: raw stop button, active-high.
- `sw_speed` input 4: free-run divider; issue every `sw_speed+1` cycles.
- `cpu_halted` input 1: core has executed halt (level).
- `cpu_en` output 1: registered one-cycle instruction-issue enable.
- `mode` output 2: current state, encoded 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- `step_count` output CNT_W: number of `cpu_en` pulses issued.
- `busy` output 1: high when `mode` is RUN or STEP.

Behaviour:
- Reset (async, `rst_n`=0):
  - `mode`=00, `cpu_en`=0, `step_count`=0, `busy`=0.
  - Synchronizers, debounced levels, debounce counters and the divider counter are all cleared to 0.
  - Reset asserted mid-RUN takes effect immediately, without waiting for a clock edge.
- Per-button debounce (run, step, stop each have their own):
  - 2-FF synchronizer produces `s`.
  - Debounced level `d` and counter `c`. Threshold `T` = 1 if `in_sim`, else `DEBOUNCE_CYCLES`.
  - Each edge where `s`≠`d`: `c`++. When `c` reaches `T`−1 and `s`≠`d` still holds, `d`<=`s` and `c`<=0.
  - Any edge where `s`==`d` sets `c`<=0, so glitches shorter than `T` cycles are rejected.
  - Press pulse is registered and high for exactly the one cycle in which `d` rises 0→1. Releases produce nothing.
  - Latency: raw rise before edge 1 → press pulse after edge 2+`T` (edge 6 for `T`=4, edge 3 for `in_sim`=1).
- FSM (registered), evaluated each edge. Priority: `cpu_halted` > stop > step > run.
  - IDLE:
    - `cpu_halted` → HALT.
    - step press → STEP.
    - run press → RUN; divider cleared to 0.
    - stop press → stays IDLE.
  - RUN:
    - `cpu_halted` → HALT.
    - stop press → IDLE.
    - step and run presses are ignored.
  - STEP:
    - Lasts exactly one cycle with `cpu_en`=1.
    - Next state is HALT if `cpu_halted`, else IDLE.
    - Presses arriving during STEP are dropped.
  - HALT:
    - Terminal; all presses are ignored, `cpu_en`=0.
    - Exited only by reset.
- `cpu_en`:
  - Registered together with the state: 1 in the cycle `mode` becomes STEP.
  - In RUN: 1 on the edge where the divider counter `div` ≥ `sw_speed`, and `div` is then reset to 0; otherwise `div`++.
  - `sw_speed`=0 gives `cpu_en` every cycle in RUN. `sw_speed` is sampled live; lowering it below the current `div` fires on the next edge.
  - A transition out of RUN (stop or halt) forces `cpu_en`=0 on that edge.
- `step_count`:
  - Increments on every edge where `cpu_en` is registered to 1.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- `busy` is a registered decode of `mode`.

Test Plan:
1. Assert `rst_n`=0, then release.
   → `mode`=00, `cpu_en`=0, `step_count`=0, `busy`=0. No `cpu_en` for 50 cycles with the buttons idle.
2. `in_sim`=0, `btn_step` held high for 10 cycles, rising before edge 1.
   → exactly one `cpu_en` pulse, registered at edge 7.
   → `mode`=10 for that cycle, then 00.
   → `step_count`=1.
3. `btn_run` pulses high for 3 cycles (`in_sim`=0).
   → no press detected; `mode` stays 00 and `cpu_en` never asserts.
4. `in_sim`=1, `sw_speed`=2, press run, wait 30 cycles, then press stop.
   → `cpu_en` pulses every 3rd cycle during RUN.
   → after stop registers, `mode`=00 and no further pulses.
   → `step_count` equals the number of pulses counted.
5. In RUN with `sw_speed`=0, raise `cpu_halted`; then press run and step.
   → `mode`=11 on the next edge with `cpu_en`=0.
   → presses are ignored; `step_count` is frozen.
   → asserting `rst_n`=0 mid-cycle clears `mode` to 00 immediately.
6. Stop press and `cpu_halted` arrive on the same edge in RUN.
   → `mode`=11. Separately, force `step_count` to 0xFFFF: a further step leaves it at 0xFFFF.
